// File: rtl/seq_stim_gen.sv
// Serial stimulus generator: shifts a latched pattern out MSB-first on w_o for a set number of passes.
// Optional PRBS-7 source enabled by defining SEQ_STIM_PRBS_EN (adds prbs_sel_i).
module seq_stim_gen #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  step_i,
    input  logic                  abort_i,
    input  logic [(2**IDX_W)-1:0] pattern_i,
    input  logic [IDX_W:0]        len_i,
    input  logic [REP_W-1:0]      repeat_i,
`ifdef SEQ_STIM_PRBS_EN
    input  logic                  prbs_sel_i,
`endif
    output logic                  w_o,
    output logic                  w_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [IDX_W-1:0]      bit_idx_o
);

    localparam int unsigned PatW = 2**IDX_W;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [PatW-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [REP_W-1:0]  pass_q, pass_d;
    logic              cont_q, cont_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              w_q, w_d;
    logic              w_valid_q, w_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  len_last;
`ifdef SEQ_STIM_PRBS_EN
    logic              prbs_q, prbs_d;
    logic [6:0]        lfsr_q, lfsr_d;
`endif

    // Index of the first bit sent; out-of-range lengths fall back to the full pattern.
    always_comb begin
        len_last = IDX_W'(PatW - 1);
        if (len_i != '0 && len_i <= (IDX_W+1)'(PatW)) begin
            len_last = IDX_W'(len_i - (IDX_W+1)'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        last_d  = last_q;
        pass_d  = pass_q;
        cont_d  = cont_q;
        idx_d   = idx_q;
`ifdef SEQ_STIM_PRBS_EN
        prbs_d  = prbs_q;
        lfsr_d  = lfsr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    state_d = StShift;
                    pat_d   = pattern_i;
                    last_d  = len_last;
                    pass_d  = repeat_i;
                    cont_d  = (repeat_i == '0);
                    idx_d   = len_last;
`ifdef SEQ_STIM_PRBS_EN
                    prbs_d  = prbs_sel_i;
                    lfsr_d  = (pattern_i[6:0] == 7'd0) ? 7'h7F : pattern_i[6:0];
`endif
                end
            end
            StShift: begin
                if (abort_i) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else if (step_i) begin
`ifdef SEQ_STIM_PRBS_EN
                    lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
`endif
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else if (cont_q || pass_q > REP_W'(1)) begin
                        // Wrap straight into the next pass with no idle bit.
                        idx_d = last_q;
                        if (!cont_q) begin
                            pass_d = pass_q - REP_W'(1);
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are computed from next state so that they can be registered without latency.
    always_comb begin
        busy_d    = (state_d != StIdle);
        w_valid_d = (state_d == StShift);
        done_d    = (state_d == StDone);
        w_d       = 1'b0;
        if (state_d == StShift) begin
`ifdef SEQ_STIM_PRBS_EN
            w_d = prbs_d ? lfsr_d[6] : pat_d[idx_d];
`else
            w_d = pat_d[idx_d];
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pat_q     <= '0;
            last_q    <= '0;
            pass_q    <= '0;
            cont_q    <= 1'b0;
            idx_q     <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_STIM_PRBS_EN
            prbs_q    <= 1'b0;
            lfsr_q    <= '0;
`endif
        end else begin
            pat_q     <= pat_d;
            last_q    <= last_d;
            pass_q    <= pass_d;
            cont_q    <= cont_d;
            idx_q     <= idx_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_STIM_PRBS_EN
            prbs_q    <= prbs_d;
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign w_o       = w_q;
    assign w_valid_o = w_valid_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign bit_idx_o = idx_q;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Scoreboard bench for seq_stim_gen: stimulus pushes expected bits/done, a negedge monitor pops them.
// PRBS cases are compiled in when SEQ_STIM_PRBS_EN is defined.
module tb_seq_stim_gen;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned REP_W = 4;
    localparam int unsigned PAT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             step = 1'b0;
    logic             abort = 1'b0;
    logic             prbs_sel = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [IDX_W:0]   len = '0;
    logic [REP_W-1:0] rep = '0;
    logic             w, w_valid, busy, done;
    logic [IDX_W-1:0] bit_idx;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit is_done;
        bit w;
        int idx;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    seq_stim_gen #(.IDX_W(IDX_W), .REP_W(REP_W)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .step_i    (step),
        .abort_i   (abort),
        .pattern_i (pattern),
        .len_i     (len),
        .repeat_i  (rep),
`ifdef SEQ_STIM_PRBS_EN
        .prbs_sel_i(prbs_sel),
`endif
        .w_o       (w),
        .w_valid_o (w_valid),
        .busy_o    (busy),
        .done_o    (done),
        .bit_idx_o (bit_idx)
    );

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: expand one transfer into the bit list it must produce.
    task automatic push_model(input logic [PAT_W-1:0] pat, input logic [IDX_W:0] ln,
                              input logic [REP_W-1:0] r, input bit prbs, input int cont_passes);
        int L;
        int passes;
        logic [6:0] s;
        exp_t e;
        L = (ln == 0 || int'(ln) > PAT_W) ? PAT_W : int'(ln);
        passes = (r == 0) ? cont_passes : int'(r);
        s = (pat[6:0] == 7'd0) ? 7'h7F : pat[6:0];
        for (int p = 0; p < passes; p++) begin
            for (int i = L - 1; i >= 0; i--) begin
                e.is_done = 1'b0;
                e.idx = i;
                e.w = prbs ? s[6] : pat[i];
                q.push_back(e);
                if (prbs) s = {s[5:0], s[6] ^ s[5]};
            end
        end
        if (r != 0) begin
            e.is_done = 1'b1;
            e.w = 1'b0;
            e.idx = 0;
            q.push_back(e);
        end
    endtask

    // Monitor: a new bit is presented after any edge that advanced (step=1) or after idle.
    bit   fresh = 1'b1;
    logic last_w = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            fresh = 1'b1;
        end else begin
            if (w_valid) begin
                chk_eq("busy_in_shift", busy, 1);
                chk_eq("done_in_shift", done, 0);
                if (fresh) begin
                    chk_eq("bit_available", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk_eq("bit_kind", e.is_done, 0);
                        chk_eq("w", w, e.w);
                        chk_eq("bit_idx", bit_idx, e.idx);
                    end
                    last_w = w;
                end else begin
                    chk_eq("w_hold", w, last_w);
                end
            end else if (done) begin
                chk_eq("done_expected", q.size() > 0 && q[0].is_done, 1);
                if (q.size() > 0 && q[0].is_done) void'(q.pop_front());
                chk_eq("done_w", w, 0);
                chk_eq("done_busy", busy, 1);
            end else begin
                chk_eq("idle_busy", busy, 0);
                chk_eq("idle_w", w, 0);
                chk_eq("idle_bit_idx", bit_idx, 0);
            end
            fresh = !w_valid || step;
        end
    end

    task automatic run(input logic [PAT_W-1:0] pat, input logic [IDX_W:0] ln,
                       input logic [REP_W-1:0] r, input bit prbs, input int step_mode,
                       input int abort_at, input bit noise, output int cycles);
        @(posedge clk); #1;
        pattern = pat; len = ln; rep = r; prbs_sel = prbs;
        start = 1'b1; abort = 1'b0; step = 1'($urandom_range(0, 1));
        push_model(pat, ln, r, prbs, 4);
        @(posedge clk); #1;
        start = 1'b0;
        chk_eq("start_latency", w_valid, 1);
        cycles = 0;
        while (busy && cycles < 4000) begin
            case (step_mode)
                0:       step = 1'b1;
                1:       step = 1'(cycles % 2);
                default: step = 1'($urandom_range(0, 1));
            endcase
            abort = (cycles == abort_at);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                pattern = 16'($urandom);
                len = 5'($urandom);
                rep = 4'($urandom);
                prbs_sel = 1'($urandom);
            end
            @(posedge clk); #1;
            cycles++;
            if (abort) begin
                q.delete();
                abort = 1'b0;
                chk_eq("abort_busy", busy, 0);
                chk_eq("abort_w_valid", w_valid, 0);
            end
        end
        start = 1'b0;
        chk_eq("no_timeout", cycles < 4000, 1);
        chk_eq("queue_drained", q.size(), 0);
        q.delete();
    endtask

    task automatic reset_mid();
        int n;
        @(posedge clk); #1;
        pattern = 16'h00F0; len = 5'd8; rep = 4'd1; prbs_sel = 1'b0; start = 1'b1; step = 1'b1;
        push_model(16'h00F0, 5'd8, 4'd1, 1'b0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (bit_idx != 2 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("reach_idx2", bit_idx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_w", w, 0);
        chk_eq("arst_w_valid", w_valid, 0);
        chk_eq("arst_busy", busy, 0);
        chk_eq("arst_bit_idx", bit_idx, 0);
        chk_eq("arst_done", done, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("post_rst_busy", busy, 0);
        chk_eq("post_rst_w_valid", w_valid, 0);
    endtask

    initial begin
        int cyc;
        logic [PAT_W-1:0] rp;
        logic [IDX_W:0] rl;
        logic [REP_W-1:0] rr;
        bit rprbs;
        int ab;

        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_w", w, 0);
        chk_eq("rst_w_valid", w_valid, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_bit_idx", bit_idx, 0);
        #11;
        rst_n = 1'b1;

        run(16'h00F0, 5'd8, 4'd1, 1'b0, 0, -1, 1'b0, cyc);
        chk_eq("t1_busy_cycles", cyc, 9);
        run(16'h000A, 5'd4, 4'd2, 1'b0, 0, -1, 1'b0, cyc);
        chk_eq("t2_busy_cycles", cyc, 9);
        run(16'h00F0, 5'd8, 4'd1, 1'b0, 1, -1, 1'b0, cyc);
        chk_eq("t3_busy_cycles", cyc, 17);
        // Second time bit_idx reaches 5 is 26 steps in; start pulses and input churn must be ignored.
        run(16'h8001, 5'd0, 4'd0, 1'b0, 0, 26, 1'b1, cyc);
        chk_eq("t4_busy_cycles", cyc, 27);
        reset_mid();
`ifdef SEQ_STIM_PRBS_EN
        run(16'hFF80, 5'd16, 4'd1, 1'b1, 0, -1, 1'b0, cyc);
        chk_eq("prbs_busy_cycles", cyc, 17);
`endif

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk_eq("start_abort_busy", busy, 0);
        chk_eq("start_abort_w_valid", w_valid, 0);

        for (int t = 0; t < 40; t++) begin
            rp = 16'($urandom);
            rl = 5'($urandom_range(0, 31));
            rr = 4'($urandom_range(1, 3));
`ifdef SEQ_STIM_PRBS_EN
            rprbs = 1'($urandom_range(0, 1));
`else
            rprbs = 1'b0;
`endif
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
            run(rp, rl, rr, rprbs, int'($urandom_range(0, 2)), ab, 1'($urandom_range(0, 1)), cyc);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
